// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared encodings for the multicycle CPU controller.
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXER     = 4'd6,
    S_EXEI     = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;
  function automatic logic [1:0] alu_dec(input logic [3:0] cmd);
    return (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
           (cmd == CMD_AND) ? ALU_AND :
           (cmd == CMD_ORR) ? ALU_ORR : ALU_ADD;
  endfunction
endpackage

// File: rtl/multicycle_controller_cond_unit.sv
// cond_unit: NZCV flag register with split N/Z and C/V write enables, plus condition check.
module cond_unit
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  output logic [3:0] flags,
  output logic       cond_ok
);
  logic [3:0] flags_q;
  logic n, z, c, v, ge, base;
  assign flags = flags_q;
  assign {n, z, c, v} = flags_q;
  assign ge = (n == v);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0000;
    else begin
      if (flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
      if (flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
    end
  end
  // Even codes test a predicate, odd codes its inverse; AL/NV share the top slot.
  always_comb begin
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = ge;
      3'd6:    base = ~z & ge;
      default: base = 1'b1;
    endcase
    cond_ok = (cond == COND_NV) ? 1'b0 : base ^ cond[0];
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH..WRITEBACK sequencer driving the shared ALU/memory datapath.
module multicycle_controller
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       ir_write,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_w,
  output logic       reg_w,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [1:0] alu_control,
  output logic [3:0] flags,
  output logic [3:0] state
);
  state_t state_q, state_d;
  logic [3:0] cmd;
  logic [1:0] flag_w;
  logic cond_ok, is_cmp, exe, set_nz, arith, rd_pc;
  logic ir_we, pc_we, mem_we, reg_we;
  assign cmd    = funct[4:1];
  assign is_cmp = (cmd == CMD_CMP);
  assign exe    = (state_q == S_EXER) || (state_q == S_EXEI);
  assign set_nz = funct[0] | is_cmp;
  assign arith  = (cmd == CMD_ADD) || (cmd == CMD_SUB) || is_cmp;
  assign flag_w = exe ? {set_nz, set_nz & arith} : 2'b00;
  assign rd_pc  = (rd == PC_REG);
  assign state  = state_q;
  cond_unit u_cond (
    .clk      (clk),
    .rst_n    (rst_n),
    .cond     (cond),
    .alu_flags(alu_flags),
    .flag_w   (flag_w),
    .flags    (flags),
    .cond_ok  (cond_ok)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else state_q <= state_d;
  end
  always_comb begin
    state_d     = state_q;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    adr_src     = 1'b0;
    mem_we      = 1'b0;
    reg_we      = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RD2;
    result_src  = RES_ALUOUT;
    imm_src     = IMM_DP;
    reg_src     = 2'b00;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_we      = 1'b1;
        pc_we      = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        reg_src    = 2'b01;
        state_d    = !cond_ok ? S_FETCH :
                     op == 2'd0 ? (funct[5] ? S_EXEI : S_EXER) :
                     op == 2'd1 ? S_MEMADR :
                     op == 2'd2 ? S_BRANCH : S_FETCH;
      end
      S_EXER, S_EXEI: begin
        alu_src_b   = (state_q == S_EXEI) ? SRCB_IMM : SRCB_RD2;
        alu_control = alu_dec(cmd);
        state_d     = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        pc_we   = rd_pc;
        state_d = S_FETCH;
      end
      S_MEMADR: begin
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_MEM;
        reg_src   = 2'b10;
        state_d   = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_we     = 1'b1;
        pc_we      = rd_pc;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_we  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        reg_src    = 2'b01;
        alu_src_b  = SRCB_IMM;
        imm_src    = IMM_BR;
        result_src = RES_ALU;
        pc_we      = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end
  // Write enables are masked during reset so an abort never leaks a store or register write.
  assign ir_write = ir_we & rst_n;
  assign pc_write = pc_we & rst_n;
  assign mem_w    = mem_we & rst_n;
  assign reg_w    = reg_we & rst_n;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven instruction sequences checked through an expected-output queue.
module tb_multicycle_controller;
  import cpu_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] cond = 4'b1110, rd = 4'd0, alu_flags = 4'd0;
  logic [1:0] op = 2'd0;
  logic [5:0] funct = 6'd0;
  logic ir_write, pc_write, adr_src, mem_w, reg_w, alu_src_a;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src, alu_control;
  logic [3:0] flags, state;
  typedef struct {
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] af;
    int n;
    logic [0:4][3:0] p;
    logic [1:0] alu;
    logic [3:0] fl;
  } vec_t;
  typedef struct {
    logic [3:0] st;
    logic ir, pc, mw, rw;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int checks = 0, fails = 0;
  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct), .rd(rd),
    .alu_flags(alu_flags), .ir_write(ir_write), .pc_write(pc_write), .adr_src(adr_src),
    .mem_w(mem_w), .reg_w(reg_w), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
    .alu_control(alu_control), .flags(flags), .state(state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] st, input logic [3:0] rdv);
    exp_t e;
    e.st = st;
    e.ir = (st == S_FETCH);
    e.pc = (st == S_FETCH) || (st == S_BRANCH) || ((st == S_ALUWB || st == S_MEMWB) && rdv == 4'd15);
    e.mw = (st == S_MEMWRITE);
    e.rw = (st == S_ALUWB) || (st == S_MEMWB);
    return e;
  endfunction
  task automatic add(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                     input logic [3:0] r, input logic [3:0] a, input int n,
                     input logic [0:4][3:0] p, input logic [1:0] alu, input logic [3:0] fl);
    vec_t v;
    v.cond = c; v.op = o; v.funct = f; v.rd = r; v.af = a; v.n = n; v.p = p; v.alu = alu; v.fl = fl;
    vecs.push_back(v);
  endtask
  task automatic run(input int id, input vec_t v);
    exp_t e;
    cond = v.cond; op = v.op; funct = v.funct; rd = v.rd; alu_flags = v.af;
    for (int k = 0; k < v.n; k++) sb.push_back(model(v.p[k], v.rd));
    for (int k = 0; k < v.n; k++) begin
      e = sb.pop_front();
      chk($sformatf("v%0d c%0d state", id, k), state, e.st);
      chk($sformatf("v%0d c%0d ir_write", id, k), ir_write, e.ir);
      chk($sformatf("v%0d c%0d pc_write", id, k), pc_write, e.pc);
      chk($sformatf("v%0d c%0d mem_w", id, k), mem_w, e.mw);
      chk($sformatf("v%0d c%0d reg_w", id, k), reg_w, e.rw);
      if (e.st == S_EXER || e.st == S_EXEI) chk($sformatf("v%0d alu_control", id), alu_control, v.alu);
      @(posedge clk);
      @(negedge clk);
    end
    chk($sformatf("v%0d flags", id), flags, v.fl);
    chk($sformatf("v%0d back to fetch", id), state, S_FETCH);
  endtask
  initial begin
    add(4'b1110, 2'd0, 6'b001000, 4'd1,  4'b1111, 4, '{S_FETCH, S_DECODE, S_EXER, S_ALUWB, S_FETCH}, 2'b00, 4'b0000);
    add(4'b1110, 2'd0, 6'b010101, 4'd0,  4'b0100, 3, '{S_FETCH, S_DECODE, S_EXER, S_FETCH, S_FETCH}, 2'b01, 4'b0100);
    add(4'b0000, 2'd2, 6'b000000, 4'd0,  4'b1111, 3, '{S_FETCH, S_DECODE, S_BRANCH, S_FETCH, S_FETCH}, 2'b00, 4'b0100);
    add(4'b0001, 2'd2, 6'b000000, 4'd0,  4'b1111, 2, '{S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH}, 2'b00, 4'b0100);
    add(4'b1110, 2'd1, 6'b011001, 4'd15, 4'b1111, 5, '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB}, 2'b00, 4'b0100);
    add(4'b1110, 2'd1, 6'b011000, 4'd2,  4'b1111, 4, '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH}, 2'b00, 4'b0100);
    add(4'b1110, 2'd3, 6'b001001, 4'd1,  4'b1111, 2, '{S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH}, 2'b00, 4'b0100);
    add(4'b1111, 2'd0, 6'b001001, 4'd1,  4'b1111, 2, '{S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH}, 2'b00, 4'b0100);
    add(4'b1110, 2'd0, 6'b100101, 4'd4,  4'b1011, 4, '{S_FETCH, S_DECODE, S_EXEI, S_ALUWB, S_FETCH}, 2'b01, 4'b1011);
    add(4'b1110, 2'd0, 6'b000001, 4'd3,  4'b0100, 4, '{S_FETCH, S_DECODE, S_EXER, S_ALUWB, S_FETCH}, 2'b10, 4'b0111);
    add(4'b1010, 2'd0, 6'b011000, 4'd15, 4'b1111, 2, '{S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH}, 2'b00, 4'b0111);
    add(4'b1011, 2'd0, 6'b011000, 4'd15, 4'b1111, 4, '{S_FETCH, S_DECODE, S_EXER, S_ALUWB, S_FETCH}, 2'b11, 4'b0111);
    repeat (3) begin
      @(negedge clk);
      chk("reset ir_write", ir_write, 1'b0);
      chk("reset pc_write", pc_write, 1'b0);
      chk("reset state", state, S_FETCH);
    end
    rst_n = 1'b1;
    #1;
    chk("post-reset ir_write", ir_write, 1'b1);
    chk("post-reset pc_write", pc_write, 1'b1);
    chk("post-reset flags", flags, 4'b0000);
    foreach (vecs[i]) run(i, vecs[i]);
    cond = 4'b1110; op = 2'd1; funct = 6'b011000; rd = 4'd2;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort pre state", state, S_MEMWRITE);
    chk("abort pre mem_w", mem_w, 1'b1);
    chk("abort pre flags", flags, 4'b0111);
    #2 rst_n = 1'b0;
    #1;
    chk("abort mem_w", mem_w, 1'b0);
    chk("abort state", state, S_FETCH);
    chk("abort flags", flags, 4'b0000);
    chk("abort reg_w", reg_w, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort release ir_write", ir_write, 1'b1);
    run(99, vecs[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
